// File: rtl/rank_cmd_fsm.sv
// Per-bank DRAM command sequencer: validates scheduler commands against bank state and arms the timing counter.
// Optional watchdog on wait states is built when RANK_CMD_WATCHDOG_EN is defined.
module rank_cmd_fsm #(
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_RFC = 40,
  parameter int T_WR  = 6,
  parameter int ROW_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [ROW_W-1:0] req_row,
  output logic             dram_cmd_valid,
  output logic [2:0]       dram_cmd,
  output logic             timer_setup,
  output logic [5:0]       timer_load,
  input  logic             timer_done,
  output logic             bank_open,
  output logic [ROW_W-1:0] open_row,
  output logic             cmd_err,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT_WAIT, S_ACTIVE, S_WR_REC, S_PRE_WAIT, S_REF_WAIT
  } state_t;

  localparam logic [2:0] C_ACT = 3'd0;
  localparam logic [2:0] C_RD  = 3'd1;
  localparam logic [2:0] C_WR  = 3'd2;
  localparam logic [2:0] C_PRE = 3'd3;
  localparam logic [2:0] C_REF = 3'd4;

  // The counter never fires on a load of 0, so the floor is 1.
  function automatic logic [5:0] clamp_load(input int v);
    if (v < 1)       return 6'd1;
    else if (v > 63) return 6'd63;
    else             return 6'(v);
  endfunction

  localparam logic [5:0] L_RCD = clamp_load(T_RCD);
  localparam logic [5:0] L_RP  = clamp_load(T_RP);
  localparam logic [5:0] L_RFC = clamp_load(T_RFC);
  localparam logic [5:0] L_WR  = clamp_load(T_WR);

  state_t     state, state_n;
  logic       accept, in_wait;
  logic       issue, err, setup, open_set, open_clr, wd_hit;
  logic [5:0] load_n;

  assign req_ready = (state == S_IDLE) || (state == S_ACTIVE);
  assign accept    = req_valid && req_ready;
  assign in_wait   = !req_ready;

`ifdef RANK_CMD_WATCHDOG_EN
  logic [7:0] wd;
  assign wd_hit = in_wait && !timer_done && (wd == 8'd126);
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    err      = 1'b0;
    setup    = 1'b0;
    load_n   = timer_load;
    open_set = 1'b0;
    open_clr = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        case (req_cmd)
          C_ACT: begin
            state_n = S_ACT_WAIT; issue = 1'b1; setup = 1'b1;
            load_n = L_RCD; open_set = 1'b1;
          end
          C_REF: begin
            state_n = S_REF_WAIT; issue = 1'b1; setup = 1'b1; load_n = L_RFC;
          end
          default: err = 1'b1;
        endcase
      end
      S_ACTIVE: if (accept) begin
        case (req_cmd)
          C_RD: issue = 1'b1;
          C_WR: begin
            state_n = S_WR_REC; issue = 1'b1; setup = 1'b1; load_n = L_WR;
          end
          C_PRE: begin
            state_n = S_PRE_WAIT; issue = 1'b1; setup = 1'b1;
            load_n = L_RP; open_clr = 1'b1;
          end
          default: err = 1'b1;
        endcase
      end
      S_ACT_WAIT: if (timer_done) state_n = S_ACTIVE;
      S_WR_REC:   if (timer_done) state_n = S_ACTIVE;
      S_PRE_WAIT: if (timer_done) state_n = S_IDLE;
      S_REF_WAIT: if (timer_done) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    // A stuck counter abandons the bank: close it and return to idle.
    if (wd_hit) begin
      state_n  = S_IDLE;
      open_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      dram_cmd_valid <= 1'b0;
      dram_cmd       <= 3'd0;
      cmd_err        <= 1'b0;
      timer_setup    <= 1'b0;
      timer_load     <= 6'd0;
      bank_open      <= 1'b0;
      open_row       <= '0;
    end else begin
      state          <= state_n;
      dram_cmd_valid <= issue;
      dram_cmd       <= issue ? req_cmd : 3'd0;
      cmd_err        <= err;
      timer_setup    <= setup;
      timer_load     <= load_n;
      if (open_set) begin
        bank_open <= 1'b1;
        open_row  <= req_row;
      end else if (open_clr) begin
        bank_open <= 1'b0;
      end
    end
  end

`ifdef RANK_CMD_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd          <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      if (setup)        wd <= 8'd0;
      else if (in_wait) wd <= wd + 8'd1;
      if (wd_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rank_cmd_fsm.sv
// Randomized bench for rank_cmd_fsm against a bank-level model (open/busy flags, command legality table).
module tb_rank_cmd_fsm;
  localparam int ROW_W = 14;
  localparam bit [2:0] ACT = 3'd0, RD = 3'd1, WR = 3'd2, PRE = 3'd3, REF = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             req_valid = 1'b0, req_ready;
  logic [2:0]       req_cmd = 3'd0;
  logic [ROW_W-1:0] req_row = '0;
  logic             dram_cmd_valid, timer_setup, timer_done = 1'b0;
  logic             bank_open, cmd_err, timeout_err;
  logic [2:0]       dram_cmd;
  logic [5:0]       timer_load;
  logic [ROW_W-1:0] open_row;

  rank_cmd_fsm #(.T_RCD(4), .T_RP(4), .T_RFC(40), .T_WR(6), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_row(req_row), .dram_cmd_valid(dram_cmd_valid),
    .dram_cmd(dram_cmd), .timer_setup(timer_setup), .timer_load(timer_load),
    .timer_done(timer_done), .bank_open(bank_open), .open_row(open_row),
    .cmd_err(cmd_err), .timeout_err(timeout_err));

  // Two extra instances only exercise the load clamp.
  logic             v2 = 1'b0, lo_ready, hi_ready, lo_cv, hi_cv, lo_setup, hi_setup;
  logic             lo_open, hi_open, lo_err, hi_err, lo_to, hi_to;
  logic [2:0]       c2 = 3'd0, lo_cmd, hi_cmd;
  logic [5:0]       lo_load, hi_load;
  logic [ROW_W-1:0] lo_row, hi_row;
  logic             no_done = 1'b0;
  logic [ROW_W-1:0] row2 = '0;

  rank_cmd_fsm #(.T_RFC(0), .ROW_W(ROW_W)) dut_lo (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(lo_ready), .req_cmd(c2),
    .req_row(row2), .dram_cmd_valid(lo_cv), .dram_cmd(lo_cmd), .timer_setup(lo_setup),
    .timer_load(lo_load), .timer_done(no_done), .bank_open(lo_open), .open_row(lo_row),
    .cmd_err(lo_err), .timeout_err(lo_to));

  rank_cmd_fsm #(.T_RFC(70), .ROW_W(ROW_W)) dut_hi (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(hi_ready), .req_cmd(c2),
    .req_row(row2), .dram_cmd_valid(hi_cv), .dram_cmd(hi_cmd), .timer_setup(hi_setup),
    .timer_load(hi_load), .timer_done(no_done), .bank_open(hi_open), .open_row(hi_row),
    .cmd_err(hi_err), .timeout_err(hi_to));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bank model: open row flag, busy while a timer wait is outstanding.
  bit               m_open, m_busy;
  bit [ROW_W-1:0]   m_row;
  bit               e_valid, e_err, e_setup;
  bit [2:0]         e_cmd;
  int               e_load;
  int               tcnt, tdelay;
  bit               rnd_delay, spur;

  function automatic int load_for(input bit [2:0] c);
    case (c)
      ACT:     return 4;
      WR:      return 6;
      PRE:     return 4;
      default: return 40;
    endcase
  endfunction

  task automatic cyc(input bit v, input bit [2:0] c, input bit [ROW_W-1:0] r);
    bit d, legal;
    chk("req_ready", req_ready, !m_busy);
    d = (tcnt == 1);
    if (tcnt > 0) tcnt--;
    if (spur && !m_busy && $urandom_range(0, 7) == 0) d = 1'b1;
    req_valid = v; req_cmd = c; req_row = r; timer_done = d;
    e_valid = 0; e_err = 0; e_setup = 0;
    if (m_busy) begin
      if (d) m_busy = 0;
    end else if (v) begin
      legal = m_open ? (c == RD || c == WR || c == PRE) : (c == ACT || c == REF);
      if (!legal) e_err = 1;
      else begin
        e_valid = 1; e_cmd = c;
        if (c != RD) begin
          e_setup = 1; e_load = load_for(c); m_busy = 1;
          tcnt = rnd_delay ? $urandom_range(2, 6) : tdelay;
        end
        if (c == ACT) begin m_open = 1; m_row = r; end
        if (c == PRE) m_open = 0;
      end
    end
    @(posedge clk); @(negedge clk);
    chk("cmd_valid", dram_cmd_valid, e_valid);
    if (e_valid) chk("dram_cmd", dram_cmd, e_cmd);
    chk("cmd_err", cmd_err, e_err);
    chk("timer_setup", timer_setup, e_setup);
    chk("timer_load", timer_load, e_load);
    chk("bank_open", bank_open, m_open);
    chk("open_row", open_row, m_row);
    chk("timeout_err", timeout_err, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && m_busy; i++) cyc(0, 3'd0, '0);
    chk("wait_bound", m_busy, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; timer_done = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_cmd_valid", dram_cmd_valid, 0);
    chk("rst_cmd", dram_cmd, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_setup", timer_setup, 0);
    chk("rst_load", timer_load, 0);
    chk("rst_open", bank_open, 0);
    chk("rst_row", open_row, 0);
    chk("rst_timeout", timeout_err, 0);
    m_open = 0; m_busy = 0; m_row = '0; e_load = 0; tcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    bit [2:0] c;
    int x;
    spur = 0; rnd_delay = 0; tdelay = 5;
    apply_reset();

    // Load clamp on the side instances; main DUT idles meanwhile.
    v2 = 1'b1; c2 = REF;
    cyc(0, 3'd0, '0);
    v2 = 1'b0;
    chk("clamp_lo_load", lo_load, 1);
    chk("clamp_hi_load", hi_load, 63);
    chk("clamp_lo_setup", lo_setup, 1);
    chk("clamp_hi_setup", hi_setup, 1);

    cyc(1, ACT, 14'h1A5);
    wait_ready();
    repeat (3) cyc(1, RD, '0);
    cyc(1, WR, '0);
    wait_ready();
    cyc(1, PRE, '0);
    wait_ready();
    cyc(1, RD, '0);
    cyc(1, ACT, 14'h2B7);
    wait_ready();
    cyc(1, 3'd6, '0);
    cyc(1, PRE, '0);
    wait_ready();
    tdelay = 0;
    cyc(1, REF, '0);
    cyc(0, 3'd0, '0);
    cyc(0, 3'd0, '0);
    apply_reset();

    spur = 1; rnd_delay = 1;
    repeat (800) begin
      x = $urandom_range(0, 19);
      c = (x < 17) ? 3'(x % 5) : 3'(5 + x % 3);
      cyc($urandom_range(0, 9) < 7, c, ROW_W'($urandom));
    end

`ifdef RANK_CMD_WATCHDOG_EN
    apply_reset();
    spur = 0; rnd_delay = 0; tdelay = 0;
    cyc(1, ACT, 14'h0F0);
    n = 0;
    while (n < 200 && !timeout_err) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("wd_cycle", n, 127);
    chk("wd_timeout", timeout_err, 1);
    chk("wd_ready", req_ready, 1);
    chk("wd_open", bank_open, 0);
`else
    n = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rank_cmd_fsm.md
# rank_cmd_fsm

Per-bank command sequencer that accepts DRAM commands from the scheduler, checks them against the bank's open/closed state, emits the DRAM command, and arms the external timing counter (tRCD, tRP, tRFC, tWR). It sits directly upstream of the timing counter: it drives that counter's `setup`/`load` inputs and consumes its one-cycle `timeUp` pulse to leave each wait state. One instance serves one bank.

## Interface
Parameters:
- `T_RCD`, default 4: ACT→RD/WR delay, in cycles.
- `T_RP`, default 4: PRE→idle delay, in cycles.
- `T_RFC`, default 40: REF→idle delay, in cycles.
- `T_WR`, default 6: WR→next-command recovery, in cycles.
- `ROW_W`, default 14: row address width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  scheduler request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at a rising edge.
- `req_cmd`  in  3  command code: 0=ACT, 1=RD, 2=WR, 3=PRE, 4=REF; 5–7 are illegal.
- `req_row`  in  ROW_W  row for ACT; ignored for all other commands.
- `dram_cmd_valid`  out  1  one-cycle pulse; the issued command is on `dram_cmd`.
- `dram_cmd`  out  3  issued command code.
- `timer_setup`  out  1  one-cycle pulse to the timing counter's `setup`.
- `timer_load`  out  6  cycle count for the timing counter's `load`.
- `timer_done`  in  1  timing counter's `timeUp`.
- `bank_open`  out  1  a row is open.
- `open_row`  out  ROW_W  the currently open row.
- `cmd_err`  out  1  one-cycle pulse when an illegal command is dropped.
- `timeout_err`  out  1  sticky error; only present in the watchdog build (see Configuration).

## Operation
States:
- IDLE: bank closed.
- ACT_WAIT: waiting out tRCD after ACT.
- ACTIVE: row open.
- WR_REC: waiting out tWR after WR.
- PRE_WAIT: waiting out tRP after PRE.
- REF_WAIT: waiting out tRFC after REF.

`req_ready` = 1 only in IDLE or ACTIVE. It is a function of state only, not of `req_valid`.

Accepted legal commands:
- IDLE + ACT → ACT_WAIT. Latches `req_row` into `open_row` and sets `bank_open`.
- IDLE + REF → REF_WAIT.
- ACTIVE + RD → stays in ACTIVE. No timer is armed.
- ACTIVE + WR → WR_REC.
- ACTIVE + PRE → PRE_WAIT. Clears `bank_open`.

Illegal commands (accepted and dropped, state unchanged, no `dram_cmd_valid`, no timer):
- ACT or REF in ACTIVE.
- RD, WR or PRE in IDLE.
- Any code 5–7.

Exits from the wait states, each on `timer_done`=1:
- ACT_WAIT → ACTIVE.
- WR_REC → ACTIVE.
- PRE_WAIT → IDLE.
- REF_WAIT → IDLE.

Other rules:
- `timer_done` outside a wait state is ignored.
- Timer load = clamp(parameter, 1, 63). The counter never fires for a load of 0, so 0 is raised to 1; values above 63 saturate to 63.
- `timer_setup` is issued only on the acceptance of ACT, WR, PRE or REF. It is therefore never asserted while in a wait state, which guarantees it never coincides with `timer_done`.
- Reset at any point, including mid-wait: state returns to IDLE and all registers are cleared.

## Timing
- All outputs are registered. Reset values: `req_ready`=1 (IDLE); every other output 0, including `open_row` and `timer_load`.
- Acceptance at edge k:
  - `dram_cmd_valid`, `dram_cmd`, `cmd_err`, `timer_setup` and `timer_load` are valid for cycle k→k+1 only.
  - The new state, and so the new `req_ready`, takes effect after edge k.
- Back-to-back RDs in ACTIVE issue at one command per cycle.
- `timer_done` sampled high at edge m in a wait state: the state updates at edge m, and `req_ready`=1 from m onward.
- `timer_load` holds its last value between `timer_setup` pulses.
- Minimum spacing, ACT to first RD, with a counter of load N: N+3 cycles.

## Configuration
- `RANK_CMD_WATCHDOG_EN` defined:
  - An 8-bit watchdog clears on each `timer_setup` and counts every cycle spent in a wait state.
  - If it reaches 127 before `timer_done` arrives: `timeout_err` sets sticky, the FSM forces IDLE, and `bank_open` clears.
  - Only reset clears `timeout_err`.
- Macro undefined: no watchdog logic is built, and `timeout_err` is tied to 0.

## Test plan
- Reset release, then ACT with row 0x1A5, timer_done modelled as 5 cycles after setup → dram_cmd=0; timer_setup=1 with timer_load=4; bank_open=1; open_row=0x1A5; req_ready=0 until timer_done, then 1.
- In ACTIVE, 3 consecutive RDs → three dram_cmd_valid pulses with dram_cmd=1 on consecutive cycles; no timer_setup; req_ready stays 1.
- WR then PRE → timer_load=6, wait, then timer_load=4; after PRE's timer_done, state is IDLE and bank_open=0.
- RD in IDLE, and cmd 6 in ACTIVE → one cmd_err pulse each; no dram_cmd_valid; state unchanged.
- T_RFC=0 build, REF → timer_load=1. T_RFC=70 build, REF → timer_load=63.
- rst asserted mid-REF_WAIT → all outputs at reset values. With `RANK_CMD_WATCHDOG_EN` defined and timer_done withheld → timeout_err=1 at cycle 127, state IDLE.
